// File: rtl/chop_mac_pipelined_if.sv
// chop_mac_pipelined_if: operand/control/result bundle for chop_mac_pipelined.
//   master : drives operands, sign flags, HALF, acc_en, acc_clr, in_valid;
//            observes out_valid, C, ovf.
//   slave  : the MAC itself (mirror of master).
// W and G must match the parameters of the attached chop_mac_pipelined.
interface chop_mac_pipelined_if #(
  parameter int unsigned W = 6,
  parameter int unsigned G = 4
);
  logic                   in_valid;
  logic [W-1:0]           A;
  logic [W-1:0]           B;
  logic                   A_sign;
  logic                   B_sign;
  logic                   HALF;
  logic                   acc_en;
  logic                   acc_clr;
  logic                   out_valid;
  logic [2*W+2*G-1:0]     C;
  logic [1:0]             ovf;

  modport master (
    output in_valid, A, B, A_sign, B_sign, HALF, acc_en, acc_clr,
    input  out_valid, C, ovf
  );

  modport slave (
    input  in_valid, A, B, A_sign, B_sign, HALF, acc_en, acc_clr,
    output out_valid, C, ovf
  );
endinterface

// File: rtl/chop_mac_pipelined.sv
// chop_mac_pipelined: two-stage pipelined, precision-configurable MAC.
//   Stage 1 registers operands and controls; stage 2 multiplies (one WxW
//   product, or two (W/2)x(W/2) SIMD lanes when HALF=1) and loads/accumulates
//   into a 2W+2G accumulator (two independent W+G lanes in half mode) with
//   sticky per-lane overflow flags.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of chop_mac_pipelined_if (operands, controls, C, ovf,
//           out_valid)
// Constraints: W even and >= 4, G >= 2.
module chop_mac_pipelined #(
  parameter int unsigned W = 6,
  parameter int unsigned G = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  chop_mac_pipelined_if.slave  bus
);
  localparam int unsigned H  = W / 2;
  localparam int unsigned LW = W + G;
  localparam int unsigned AW = 2 * LW;

  // ModeNone forces the next accepted sample to load.
  typedef enum logic [1:0] {ModeNone, ModeFull, ModeHalf} mode_e;

  // Stage 1
  logic         v1_q;
  logic [W-1:0] a_q, b_q;
  logic         as_q, bs_q, half_q, acc_en_q, acc_clr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      as_q      <= 1'b0;
      bs_q      <= 1'b0;
      half_q    <= 1'b0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
    end else begin
      v1_q      <= bus.in_valid;
      a_q       <= bus.A;
      b_q       <= bus.B;
      as_q      <= bus.A_sign;
      bs_q      <= bus.B_sign;
      half_q    <= bus.HALF;
      acc_en_q  <= bus.acc_en;
      acc_clr_q <= bus.acc_clr;
    end
  end

  // Products
  logic                  sgn;
  logic signed [W:0]     fa, fb;
  logic signed [2*W+1:0] fp;
  logic signed [H:0]     la [2];
  logic signed [H:0]     lb [2];
  logic signed [W+1:0]   lp [2];
  logic [LW-1:0]         lext [2];
  logic [AW-1:0]         prod;

  assign sgn = as_q | bs_q;

  always_comb begin
    // Each operand gets one extra bit so a signed multiply covers both
    // signed and unsigned interpretations.
    fa = {as_q & a_q[W-1], a_q};
    fb = {bs_q & b_q[W-1], b_q};
    fp = (2*W+2)'(fa) * (2*W+2)'(fb);
    for (int i = 0; i < 2; i++) begin
      la[i]   = {as_q & a_q[i*H+H-1], a_q[i*H +: H]};
      lb[i]   = {bs_q & b_q[i*H+H-1], b_q[i*H +: H]};
      lp[i]   = (W+2)'(la[i]) * (W+2)'(lb[i]);
      lext[i] = sgn ? LW'($signed(lp[i])) : LW'($unsigned(lp[i]));
    end
    if (half_q) begin
      prod = {lext[1], lext[0]};
    end else begin
      prod = sgn ? AW'($signed(fp)) : AW'($unsigned(fp));
    end
  end

  // Stage 2: accumulator
  logic [AW-1:0] c_q, c_d;
  logic [1:0]    ovf_q, ovf_d;
  logic          out_valid_q, out_valid_d;
  mode_e         mode_q, mode_d;

  logic [AW:0]   fsum;
  logic [LW:0]   lsum [2];
  logic          fof;
  logic [1:0]    lof;
  mode_e         cur_mode;
  logic          do_acc;

  always_comb begin
    fsum = {1'b0, c_q} + {1'b0, prod};
    // Signed: operands agree in sign but the sum does not. Unsigned: carry-out.
    fof  = sgn ? ((c_q[AW-1] == prod[AW-1]) && (fsum[AW-1] != c_q[AW-1])) : fsum[AW];
    for (int i = 0; i < 2; i++) begin
      // Lanes are summed separately so no carry crosses the lane boundary.
      lsum[i] = {1'b0, c_q[i*LW +: LW]} + {1'b0, prod[i*LW +: LW]};
      lof[i]  = sgn ? ((c_q[i*LW+LW-1] == prod[i*LW+LW-1]) &&
                       (lsum[i][LW-1] != c_q[i*LW+LW-1]))
                    : lsum[i][LW];
    end
  end

  always_comb begin
    c_d         = c_q;
    ovf_d       = ovf_q;
    mode_d      = mode_q;
    out_valid_d = 1'b0;
    cur_mode    = half_q ? ModeHalf : ModeFull;
    do_acc      = acc_en_q && (mode_q == cur_mode);
    if (acc_clr_q) begin
      c_d    = '0;
      ovf_d  = '0;
      mode_d = ModeNone;
    end else if (v1_q) begin
      out_valid_d = 1'b1;
      mode_d      = cur_mode;
      if (!do_acc) begin
        c_d   = prod;
        ovf_d = '0;
      end else if (half_q) begin
        c_d   = {lsum[1][LW-1:0], lsum[0][LW-1:0]};
        ovf_d = ovf_q | lof;
      end else begin
        c_d   = fsum[AW-1:0];
        ovf_d = {ovf_q[1], ovf_q[0] | fof};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q         <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      mode_q      <= ModeNone;
    end else begin
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      mode_q      <= mode_d;
    end
  end

  assign bus.C         = c_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_chop_mac_pipelined.sv
// Directed bench for chop_mac_pipelined with an integer reference model and
// an expected-result queue popped whenever out_valid is seen.
module tb_chop_mac_pipelined;
  localparam int unsigned W  = 6;
  localparam int unsigned G  = 4;
  localparam int unsigned H  = W / 2;
  localparam int unsigned LW = W + G;
  localparam int unsigned AW = 2 * LW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chop_mac_pipelined_if #(.W(W), .G(G)) bus ();

  chop_mac_pipelined #(.W(W), .G(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [AW-1:0] c;
    logic [1:0]    ovf;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  longint     m_c = 0;
  logic [1:0] m_ovf = '0;
  int         m_mode = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sval(input longint x, input int w, input bit s);
    if (s && x[w-1]) return x - (longint'(1) << w);
    return x;
  endfunction

  // One clock; outputs observed on the falling edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (bus.out_valid === 1'b1) begin
      check("spurious_out_valid", 64'(bus.out_valid), (sb.size() > 0) ? 64'd1 : 64'd0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_C", 64'(bus.C), 64'(e.c));
        check("sb_ovf", 64'(bus.ovf), 64'(e.ovf));
      end
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input bit as,
                       input bit bs, input bit hf, input bit ae, input bit clr, input bit v);
    int     mode, nl, lw, sw;
    bit     acc, sgn, of;
    longint md, av, bv, p, old, s;
    exp_t   e;
    bus.A = a;       bus.B = b;       bus.A_sign = as; bus.B_sign = bs;
    bus.HALF = hf;   bus.acc_en = ae; bus.acc_clr = clr; bus.in_valid = v;
    if (clr) begin
      m_c = 0; m_ovf = '0; m_mode = 0;
    end else if (v) begin
      mode = hf ? 2 : 1;
      acc  = ae && (m_mode == mode);
      sgn  = as | bs;
      nl   = hf ? 2 : 1;
      lw   = hf ? int'(LW) : int'(AW);
      sw   = hf ? int'(H) : int'(W);
      md   = longint'(1) << lw;
      if (!acc) m_ovf = '0;
      for (int l = 0; l < nl; l++) begin
        av  = sval((longint'(a) >> (l * sw)) & ((longint'(1) << sw) - 1), sw, as);
        bv  = sval((longint'(b) >> (l * sw)) & ((longint'(1) << sw) - 1), sw, bs);
        p   = av * bv;
        old = (m_c >> (l * lw)) & (md - 1);
        of  = 1'b0;
        if (acc) begin
          if (sgn) begin
            s  = sval(old, lw, 1'b1) + p;
            of = (s < -(md / 2)) || (s >= md / 2);
          end else begin
            s  = old + p;
            of = (s >= md);
          end
        end else begin
          s = p;
        end
        s   = ((s % md) + md) % md;
        m_c = (m_c & ~((md - 1) << (l * lw))) | (s << (l * lw));
        if (of) m_ovf[l] = 1'b1;
      end
      m_mode = mode;
      e.c    = m_c[AW-1:0];
      e.ovf  = m_ovf;
      sb.push_back(e);
    end
    step();
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.A_sign = 1'b0; bus.B_sign = 1'b0;
    bus.HALF = 1'b0; bus.acc_en = 1'b0; bus.acc_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_C", 64'(bus.C), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;

    // Full unsigned load: two-edge latency, single-cycle out_valid.
    drive(6'd63, 6'd63, 0, 0, 0, 0, 0, 1);
    check("latency_low", 64'(bus.out_valid), 64'd0);
    idle(1);
    check("full_u_valid", 64'(bus.out_valid), 64'd1);
    check("full_u_C", 64'(bus.C), 64'd3969);
    idle(1);
    check("full_u_pulse", 64'(bus.out_valid), 64'd0);

    // Full signed, back to back.
    drive(6'b100000, 6'b011111, 1, 1, 0, 0, 0, 1);
    drive(6'b100000, 6'b100000, 1, 1, 0, 0, 0, 1);
    check("full_s_C0", 64'(bus.C), 64'h0FFC20);
    idle(1);
    check("full_s_C1", 64'(bus.C), 64'd1024);

    // Half signed lanes.
    drive(6'b101011, 6'b011110, 1, 1, 1, 0, 0, 1);
    idle(1);
    check("half_s_C", 64'(bus.C), 64'({10'h3F7, 10'h3FA}));

    // Half unsigned wrap and overflow.
    drive(6'b111111, 6'b111111, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 20; i++) drive(6'b111111, 6'b111111, 0, 0, 1, 1, 0, 1);
    idle(1);
    check("half_u_C", 64'(bus.C), 64'({10'd5, 10'd5}));
    check("half_u_ovf", 64'(bus.ovf), 64'd3);
    drive(6'b001001, 6'b001001, 0, 0, 1, 0, 0, 1);
    idle(1);
    check("half_u_ovf_clr", 64'(bus.ovf), 64'd0);

    // Mode change forces a load; clear drops the concurrent sample.
    drive(6'd5, 6'd5, 0, 0, 0, 0, 0, 1);
    drive(6'd5, 6'd5, 0, 0, 0, 1, 0, 1);
    drive(6'd5, 6'd5, 0, 0, 0, 1, 0, 1);
    idle(1);
    check("acc3_C", 64'(bus.C), 64'd75);
    drive(6'd5, 6'd5, 0, 0, 1, 1, 0, 1);
    idle(1);
    check("mode_chg_C", 64'(bus.C), 64'd25);
    drive(6'd7, 6'd7, 0, 0, 0, 1, 1, 1);
    idle(1);
    check("clr_C", 64'(bus.C), 64'd0);
    check("clr_ovf", 64'(bus.ovf), 64'd0);
    check("clr_out_valid", 64'(bus.out_valid), 64'd0);
    drive(6'd3, 6'd3, 0, 0, 0, 1, 0, 1);
    idle(1);
    check("post_clr_load", 64'(bus.C), 64'd9);
    drive(6'd0, 6'd0, 0, 0, 0, 0, 1, 0);
    idle(1);
    check("clr_novalid_C", 64'(bus.C), 64'd0);

    // Reset mid-pipeline.
    drive(6'd11, 6'd13, 0, 0, 0, 0, 0, 1);
    drive(6'd9, 6'd9, 0, 0, 0, 1, 0, 1);
    bus.A = 6'd2; bus.B = 6'd2; bus.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_C", 64'(bus.C), 64'd0);
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    sb.delete();
    m_c = 0; m_ovf = '0; m_mode = 0;
    bus.in_valid = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(4);
    check("rst_rel_C", 64'(bus.C), 64'd0);
    check("rst_rel_out_valid", 64'(bus.out_valid), 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/chop_mac_pipelined.md
# chop_mac_pipelined

Parametrised, two-stage pipelined, precision-configurable multiply-accumulate block. It extends the combinational 6x6 / dual 3x3 chop multiplier with generic operand width, a registered valid pipeline, per-lane accumulation with guard bits, and sticky overflow flags. It sits in the PIRDSP datapath wherever a DSP-style MAC must switch between one full-width product and two half-width SIMD products.

## Interface
- W, 6: operand width; even, >= 4
- G, 4: guard bits per lane accumulator
- clk  in  1  clock, all registers on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands and controls valid this cycle
- A  in  W  operand A; in half mode lane1 = A[W-1:W/2], lane0 = A[W/2-1:0]
- B  in  W  operand B, same split as A
- A_sign  in  1  1 = A (or each A sub-word) is two's complement
- B_sign  in  1  1 = B (or each B sub-word) is two's complement
- HALF  in  1  0 = one WxW product; 1 = two (W/2)x(W/2) lanes
- acc_en  in  1  1 = add product to accumulator; 0 = load product
- acc_clr  in  1  clear accumulator and flags
- out_valid  out  1  C/ovf updated by a valid sample
- C  out  2W+2G  accumulator; half mode: lane1 = C[2W+2G-1:W+G], lane0 = C[W+G-1:0]
- ovf  out  2  sticky overflow; full mode uses ovf[0], ovf[1] held 0

## Operation
- Stage 1 registers A, B, A_sign, B_sign, HALF, acc_en, acc_clr and in_valid (v1).
- Product: each operand (sub-word) extended by one bit using its sign flag (sign-extend if flag set, zero-extend otherwise), multiplied signed; result extended to accumulator width (2W+2G full, W+G per lane) by sign if A_sign|B_sign, else zero.
- Stage 2 (accumulator) update on edge when stage 1 holds:
  - acc_clr=1: C=0, ovf=0, out_valid=0; data in same stage dropped (clear wins over valid).
  - v1=1, acc_en=0: C = product (per lane), ovf cleared, out_valid=1.
  - v1=1, acc_en=1, HALF equal to mode of last accepted sample: C = C + product, modulo lane width; no carry crosses the lane boundary in half mode; out_valid=1.
  - v1=1, acc_en=1, HALF differs from last accepted mode (or first sample after reset/clear): treated as load.
  - v1=0: C and ovf hold, out_valid=0.
- Overflow per lane: signed accumulation (A_sign|B_sign) sets flag when addend and old C share sign and sum sign differs; unsigned sets flag on carry-out. Flags sticky until load, clear or reset.
- Stored mode register tracks HALF of last accepted sample; reset and clear set it to "none" (next sample always loads).

## Timing
- Latency: sample presented with in_valid in cycle n is sampled at edge n, appears on C/out_valid after edge n+1 (2 register stages).
- Throughput: one sample per cycle, no backpressure, no stall.
- out_valid is a one-cycle-per-sample pulse; back-to-back samples give continuous out_valid.
- Mode change costs no bubble; only forces a load.
- Reset (rst_n=0, any time, including mid-pipeline): stage 1 and stage 2 cleared immediately; C=0, ovf=0, out_valid=0, mode="none". No in-flight sample emerges after release.
- acc_clr with in_valid=0 still clears when it reaches stage 2 (one edge after sampling).

## Test plan
- Full unsigned load, W=6: A=63, B=63, HALF=0, signs 0, acc_en=0 -> two edges later C=3969, out_valid=1 for exactly one cycle, ovf=0.
- Full signed: A=6'b100000 (-32), B=6'b011111 (31), signs 1, acc_en=0 -> C=20'hFFC20 (-992); next sample A=-32, B=-32 -> C=1024.
- Half signed: A=6'b101011 (-3, 3), B=6'b011110 (3, -2), HALF=1, signs 1 -> C[19:10]=10'h3F7 (-9), C[9:0]=10'h3FA (-6), no cross-lane carry.
- Half unsigned accumulate/overflow: A=B=6'b111111 (7,7 per lane), one load then 20 back-to-back acc_en=1 -> 1029 mod 1024: each lane=5, ovf=2'b11; following load clears ovf to 0.
- Mode change and clear: full accumulate 3 samples of 5x5 (C=75), then HALF=1 sample with acc_en=1 -> C loaded with lane products, not added; acc_clr pulse with in_valid=1 -> C=0, ovf=0, out_valid=0, sample dropped.
- Reset mid-pipeline: drive 3 valid samples, pull rst_n low asynchronously between edges after the second -> C=0, out_valid=0 immediately; after release with in_valid=0 no out_valid pulse appears.
